// File: rtl/ma_stage.sv
// Memory Access stage: runs loads/stores over a req/ack data bus, stalls upstream while waiting,
// and owns the MAWB pipeline register. Define MA_PERF_CNT_EN to add load/store/wait counters.
module ma_stage #(
    parameter int WIDTH     = 32,
    parameter int WB_WIDTH  = 3,
    parameter int RDS_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WB_WIDTH-1:0]  i_WB_Ctrl,
    input  logic [1:0]           i_MEM_Ctrl,
    input  logic [WIDTH-1:0]     i_ALU_rslt,
    input  logic [WIDTH-1:0]     i_Rs2_val,
    input  logic [WIDTH-1:0]     i_PC,
    input  logic [RDS_WIDTH-1:0] i_Rds_addr,
    input  logic                 i_Fwrd_Store,
    input  logic [WIDTH-1:0]     i_Data_From_WB,
    input  logic                 i_MAWB_flush,
    output logic [WIDTH-1:0]     o_Data_To_EX,
    output logic                 o_MA_stall,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [WIDTH-1:0]     o_dmem_addr,
    output logic [WIDTH-1:0]     o_dmem_wdata,
    input  logic                 i_dmem_ack,
    input  logic [WIDTH-1:0]     i_dmem_rdata,
`ifdef MA_PERF_CNT_EN
    output logic [31:0]          o_load_cnt,
    output logic [31:0]          o_store_cnt,
    output logic [31:0]          o_wait_cnt,
`endif
    output logic [WB_WIDTH-1:0]  o_MAWB_WB,
    output logic [WIDTH-1:0]     o_MAWB_Mem_data,
    output logic [WIDTH-1:0]     o_MAWB_ALU_rslt,
    output logic [RDS_WIDTH-1:0] o_MAWB_Rds_addr,
    output logic [WIDTH-1:0]     o_MAWB_PC
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e         state_q, state_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic           mem_op;
    logic           is_write;
    logic           req;
    logic           done;
    logic           capture;
    logic [WIDTH-1:0] wdata_sel;

    assign mem_op    = i_MEM_Ctrl[0] | i_MEM_Ctrl[1];
    assign is_write  = i_MEM_Ctrl[1];
    assign wdata_sel = i_Fwrd_Store ? i_Data_From_WB : i_Rs2_val;

    // NOTE: always_comb with every output defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req = mem_op;
                if (mem_op && !i_dmem_ack) begin
                    state_d = WAIT;
                    wdata_d = wdata_sel;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (i_dmem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Acks with no request outstanding are ignored; a flush only overrides the MAWB load.
    assign done    = req & i_dmem_ack;
    assign capture = ~i_MAWB_flush & (((state_q == IDLE) & ~mem_op) | done);

    // The stored copy shields a waiting store from the WB forwarding source moving on.
    assign o_dmem_req   = reset & req;
    assign o_MA_stall   = reset & req & ~i_dmem_ack;
    assign o_dmem_we    = is_write;
    assign o_dmem_addr  = i_ALU_rslt;
    assign o_dmem_wdata = (state_q == WAIT) ? wdata_q : wdata_sel;
    assign o_Data_To_EX = i_ALU_rslt;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_MAWB_WB       <= '0;
            o_MAWB_Mem_data <= '0;
            o_MAWB_ALU_rslt <= '0;
            o_MAWB_Rds_addr <= '0;
            o_MAWB_PC       <= '0;
        end else if (capture) begin
            o_MAWB_WB       <= i_WB_Ctrl;
            o_MAWB_Mem_data <= (done && !is_write) ? i_dmem_rdata : '0;
            o_MAWB_ALU_rslt <= i_ALU_rslt;
            o_MAWB_Rds_addr <= i_Rds_addr;
            o_MAWB_PC       <= i_PC;
        end else begin
            o_MAWB_WB       <= '0;
            o_MAWB_Mem_data <= '0;
            o_MAWB_ALU_rslt <= '0;
            o_MAWB_Rds_addr <= '0;
            o_MAWB_PC       <= '0;
        end
    end

`ifdef MA_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_load_cnt  <= '0;
            o_store_cnt <= '0;
            o_wait_cnt  <= '0;
        end else begin
            if (done && !is_write) o_load_cnt  <= o_load_cnt + 32'd1;
            if (done && is_write)  o_store_cnt <= o_store_cnt + 32'd1;
            if (o_MA_stall)        o_wait_cnt  <= o_wait_cnt + 32'd1;
        end
    end
`endif

endmodule
